// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - i/j/k loop sequencer feeding operand addresses to the FP MAC
module matmul_seq_ctrl #(
  parameter int DIM_W  = 32,
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_num_i,
  input  logic [DIM_W-1:0]  i_num_j,
  input  logic [DIM_W-1:0]  i_num_k,
  output logic              o_op_valid,
  input  logic              i_op_ready,
  output logic [ADDR_W-1:0] o_a_addr,
  output logic [ADDR_W-1:0] o_b_addr,
  output logic              o_op_first,
  output logic              o_op_last,
  input  logic              i_acc_valid,
  output logic              o_c_we,
  output logic [ADDR_W-1:0] o_c_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACC, S_WRITE, S_DONE} state_t;

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [DIM_W-1:0]  r_ni, r_nj, r_nk;
  logic [DIM_W-1:0]  r_i, r_j, r_k;
  logic              r_err;

  logic              w_k_last, w_j_last, w_i_last, w_xfer, w_any_zero;
  logic [ADDR_W-1:0] w_a_addr, w_b_addr, w_c_addr;

  assign w_k_last   = (r_k == r_nk - ONE);
  assign w_j_last   = (r_j == r_nj - ONE);
  assign w_i_last   = (r_i == r_ni - ONE);
  assign w_xfer     = (r_state == S_ISSUE) && i_op_ready;
  assign w_any_zero = (i_num_i == '0) || (i_num_j == '0) || (i_num_k == '0);

  // Modular arithmetic: the low ADDR_W bits of the full product/sum are all we keep.
  assign w_a_addr = ADDR_W'(r_i * r_nk + r_k);
  assign w_b_addr = ADDR_W'(r_k * r_nj + r_j);
  assign w_c_addr = ADDR_W'(r_i * r_nj + r_j);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_next = w_any_zero ? S_DONE : S_ISSUE;
      S_ISSUE:    if (w_xfer && w_k_last) w_next = S_WAIT_ACC;
      S_WAIT_ACC: if (i_acc_valid) w_next = S_WRITE;
      S_WRITE:    w_next = (w_i_last && w_j_last) ? S_DONE : S_ISSUE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ni  <= '0;
      r_nj  <= '0;
      r_nk  <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_ni  <= i_num_i;
            r_nj  <= i_num_j;
            r_nk  <= i_num_k;
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_err <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (w_xfer) r_k <= w_k_last ? '0 : r_k + ONE;
        end
        S_WRITE: begin
          if (w_j_last) begin
            r_j <= '0;
            r_i <= r_i + ONE;
          end else begin
            r_j <= r_j + ONE;
          end
        end
        default: ;
      endcase
      // A stray result overrides a same-cycle clear from start.
      if (i_acc_valid && (r_state != S_WAIT_ACC)) r_err <= 1'b1;
    end
  end

  always_comb begin
    o_op_valid = 1'b0;
    o_a_addr   = '0;
    o_b_addr   = '0;
    o_op_first = 1'b0;
    o_op_last  = 1'b0;
    o_c_we     = 1'b0;
    o_c_addr   = '0;
    o_done     = 1'b0;
    o_busy     = (r_state != S_IDLE);
    o_err      = r_err;
    case (r_state)
      S_ISSUE: begin
        o_op_valid = 1'b1;
        o_a_addr   = w_a_addr;
        o_b_addr   = w_b_addr;
        o_op_first = (r_k == '0);
        o_op_last  = w_k_last;
      end
      S_WRITE: begin
        o_c_we   = 1'b1;
        o_c_addr = w_c_addr;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - directed table and sequence checks for matmul_seq_ctrl
module tb_matmul_seq_ctrl;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b0, acc = 1'b0;
  logic [31:0] ni = '0, nj = '0, nk = '0;
  logic        ov, f, l, we, dn, bz, er;
  logic [15:0] a, b, c;
  int          n_pass = 0, n_total = 0;

  matmul_seq_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .i_num_i(ni), .i_num_j(nj), .i_num_k(nk),
    .o_op_valid(ov), .i_op_ready(ready), .o_a_addr(a), .o_b_addr(b),
    .o_op_first(f), .o_op_last(l), .i_acc_valid(acc),
    .o_c_we(we), .o_c_addr(c), .o_busy(bz), .o_done(dn), .o_err(er)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        st, acc, ov;
    logic [15:0] a, b;
    logic        f, l, we;
    logic [15:0] c;
    logic        dn, bz;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic st, input logic av, input logic o, input int aa,
                              input int bb, input logic ff, input logic ll, input logic w,
                              input int cc, input logic d, input logic bsy);
    vec_t v;
    v.st = st; v.acc = av; v.ov = o; v.a = 16'(aa); v.b = 16'(bb);
    v.f = ff; v.l = ll; v.we = w; v.c = 16'(cc); v.dn = d; v.bz = bsy;
    return v;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({ov, a, b, f, l, we, c, dn, bz, er});
  endfunction

  // mode 0: plain 2x2x2; mode 1: start/num_* disturbed mid-run; mode 2: stray acc_valid in ISSUE
  task automatic run_table(input int mode);
    for (int n = 0; n < 23; n++) begin
      @(negedge clk);
      chk($sformatf("m%0d_cyc%0d", mode, n), outs(),
          64'({tbl[n].ov, tbl[n].a, tbl[n].b, tbl[n].f, tbl[n].l, tbl[n].we, tbl[n].c,
               tbl[n].dn, tbl[n].bz, (mode == 2 && n >= 2)}));
      start = tbl[n].st;
      ready = 1'b1;
      acc   = tbl[n].acc;
      if (n == 0) begin ni = 2; nj = 2; nk = 2; end
      if (mode == 1 && n >= 1 && n <= 20) begin
        start = 1'b1; ni = 5; nj = 7; nk = 3;
      end
      if (mode == 2 && n == 1) acc = 1'b1;
    end
    start = 1'b0;
    acc   = 1'b0;
  endtask

  int          nxf, nwe;
  logic        seen_done, pend, pstall, pf, pl;
  logic [15:0] pa, pb;

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 1, 1, 2, 0, 1, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[6]  = mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1);
    tbl[7]  = mk(0, 0, 1, 1, 3, 0, 1, 0, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    tbl[11] = mk(0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 1);
    tbl[12] = mk(0, 0, 1, 3, 2, 0, 1, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1);
    tbl[16] = mk(0, 0, 1, 2, 1, 1, 0, 0, 0, 0, 1);
    tbl[17] = mk(0, 0, 1, 3, 3, 0, 1, 0, 0, 0, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[19] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    rst = 1'b0;

    run_table(0);
    run_table(1);
    run_table(2);

    // 1x1x3 with op_ready stalling every other cycle
    @(negedge clk);
    start = 1'b1; ni = 1; nj = 1; nk = 3; ready = 1'b0; acc = 1'b0;
    nxf = 0; nwe = 0; seen_done = 1'b0; pend = 1'b0; pstall = 1'b0;
    pa = '0; pb = '0; pf = 1'b0; pl = 1'b0;
    for (int cy = 0; cy < 60 && !seen_done; cy++) begin
      @(negedge clk);
      start = 1'b0;
      acc   = pend;
      pend  = 1'b0;
      ready = cy[0];
      if (cy == 0) chk("t2_err_cleared", 64'(er), 64'd0);
      if (pstall) chk($sformatf("t2_stall_hold_%0d", cy), 64'({a, b, f, l}), 64'({pa, pb, pf, pl}));
      if (ov && ready) begin
        chk($sformatf("t2_xfer_k%0d", nxf), 64'({a, b, f, l}),
            64'({16'(nxf), 16'(nxf), (nxf == 0), (nxf == 2)}));
        nxf++;
        if (nxf == 3) pend = 1'b1;
      end
      pstall = ov && !ready;
      pa = a; pb = b; pf = f; pl = l;
      if (we) begin
        nwe++;
        chk("t2_c_addr", 64'(c), 64'd0);
      end
      if (dn) seen_done = 1'b1;
    end
    acc = 1'b0;
    chk("t2_xfer_count", 64'(nxf), 64'd3);
    chk("t2_write_count", 64'(nwe), 64'd1);
    chk("t2_done_seen", 64'(seen_done), 64'd1);

    // zero-sized shape: straight to DONE
    @(negedge clk);
    start = 1'b1; ni = 3; nj = 0; nk = 4;
    @(negedge clk);
    start = 1'b0;
    chk("t3_done_pulse", 64'({ov, we, dn, bz}), 64'b0011);
    @(negedge clk);
    chk("t3_back_idle", 64'({ov, we, dn, bz}), 64'b0000);

    // async reset while waiting for the accumulator
    @(negedge clk);
    start = 1'b1; ni = 1; nj = 1; nk = 1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_issue", 64'({ov, f, l, a, b}), 64'({3'b111, 16'd0, 16'd0}));
    @(negedge clk);
    chk("t6_wait", 64'({ov, bz}), 64'b01);
    #2 rst = 1'b1;
    #1 chk("t6_async_reset", outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_reissue", 64'({ov, f, l, a, b}), 64'({3'b111, 16'd0, 16'd0}));
    @(negedge clk);
    acc = 1'b1;
    @(negedge clk);
    acc = 1'b0;
    chk("t6_write", 64'({we, c}), 64'({1'b1, 16'd0}));
    @(negedge clk);
    chk("t6_done", 64'({dn, bz, er}), 64'b110);
    @(negedge clk);
    chk("t6_idle", 64'({dn, bz}), 64'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
